rf_seq_ctrl: RTL and testbench

Multicycle control FSM for the 16-bit CPU core. It fetches instructions, decodes them, and drives the 16x16 register file: read addresses, the immediate select, write address and write enable. It also sequences ALU and data-memory accesses. It sits between instruction memory, data memory, the register file and the ALU.

---
 rtl/rf_seq_ctrl_if.sv | 12 +
 rtl/rf_seq_ctrl.sv | 85 ++++++++
 tb/tb_rf_seq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_seq_ctrl_if.sv
// rf_seq_ctrl_if: instruction/data memory handshake bus between the sequencer and memories
interface rf_seq_ctrl_if #(parameter int PC_W = 8);
  logic [15:0]     imem_rdata;
  logic            imem_valid;
  logic            dmem_valid;
  logic            imem_req;
  logic [PC_W-1:0] pc;
  logic            dmem_req;
  logic            dmem_we;
  modport master(input imem_rdata, imem_valid, dmem_valid, output imem_req, pc, dmem_req, dmem_we);
  modport slave(output imem_rdata, imem_valid, dmem_valid, input imem_req, pc, dmem_req, dmem_we);
endinterface

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: multicycle fetch/decode/exec/mem/wb control FSM driving the 16x16 register file
module rf_seq_ctrl #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  rf_seq_ctrl_if.master bus,
  output logic [3:0]  rf_read_add1,
  output logic [3:0]  rf_read_add2,
  output logic [3:0]  rf_write_add,
  output logic        rf_write_en,
  output logic        immediateC,
  output logic [2:0]  alu_op,
  output logic        wb_sel,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t st, nx;
  logic [15:0] ir;
  logic [PC_W-1:0] pc_q;
  logic [7:0] cnt;
  logic [3:0] op;
  logic waiting, got, tmo, done, act;
  assign op = ir[15:12];
  always_comb begin
    waiting = st == FETCH || st == MEM;
    got     = st == FETCH ? bus.imem_valid : bus.dmem_valid;
    tmo     = waiting && !got && cnt == 8'(MEM_TIMEOUT - 1);
    illegal = st == DECODE && op inside {[4'hA:4'hE]};
    nx      = st;
    done    = 1'b0;
    case (st)
      FETCH:  nx = got ? DECODE : tmo ? HALT : FETCH;
      DECODE: begin
        done = op == 4'h0 || illegal;
        nx   = done ? FETCH : op == 4'hF ? HALT : EXEC;
      end
      EXEC:   nx = op inside {4'h8, 4'h9} ? MEM : WB;
      MEM: begin
        done = got && op == 4'h9;
        nx   = got ? (op == 4'h9 ? FETCH : WB) : tmo ? HALT : MEM;
      end
      WB: begin
        done = 1'b1;
        nx   = FETCH;
      end
      default: nx = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= FETCH;
      pc_q    <= '0;
      ir      <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      st      <= nx;
      bus_err <= tmo;
      cnt     <= waiting && !got ? cnt + 8'd1 : 8'd0;
      if (done) pc_q <= pc_q + PC_W'(1);
      if (st == FETCH && got) ir <= bus.imem_rdata;
    end
  end
  // Register-file fields are held for the whole instruction so the negedge write sees stable inputs
  always_comb begin
    act          = st inside {DECODE, EXEC, MEM, WB};
    bus.imem_req = reset && st == FETCH;
    bus.pc       = pc_q;
    bus.dmem_req = st == MEM;
    bus.dmem_we  = st == MEM && op == 4'h9;
    rf_read_add1 = act ? ir[7:4] : 4'h0;
    rf_read_add2 = act ? ir[3:0] : 4'h0;
    rf_write_add = act ? ir[11:8] : 4'h0;
    rf_write_en  = st == WB;
    wb_sel       = st == WB && op == 4'h8;
    immediateC   = act && op inside {[4'h5:4'h7]};
    alu_op       = !act ? 3'd0 : (op == 4'h2 || op == 4'h6) ? 3'd1 : op == 4'h3 ? 3'd2 :
                   op == 4'h4 ? 3'd3 : op == 4'h7 ? 3'd4 : 3'd0;
    halted       = st == HALT;
  end
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: randomized instruction stream with a per-instruction scoreboard and directed corner cases
module tb_rf_seq_ctrl;
  localparam int PC_W = 8;
  localparam int TMO  = 15;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  rf_seq_ctrl_if #(.PC_W(PC_W)) bus();
  logic [3:0] ra1, ra2, wa;
  logic we, imm, wbs, halted, berr, ill;
  logic [2:0] aop;
  rf_seq_ctrl #(.PC_W(PC_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_read_add1(ra1), .rf_read_add2(ra2), .rf_write_add(wa), .rf_write_en(we),
    .immediateC(imm), .alu_op(aop), .wb_sel(wbs), .halted(halted), .bus_err(berr), .illegal(ill)
  );

  int total = 0;
  int bad = 0;
  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  typedef struct { logic [15:0] ins; int flat; int dlat; } stim_t;
  typedef struct { int pc, npc, ra1, ra2, wa, imm, aop, nwe, wbs, nill, ncyc, ndreq, dwe, halt, berr; } exp_t;
  stim_t iq[$];
  exp_t  eq[$];
  int mpc = 0;
  int cur_dlat = 0;
  int alu_of[16] = '{0, 0, 1, 2, 3, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0};

  // Instruction-level reference: what each opcode must do, from the ISA rules
  function automatic exp_t model(logic [15:0] ins, int dl, int pc);
    exp_t e;
    int op = int'(ins[15:12]);
    bit mem = op == 8 || op == 9;
    bit to = mem && dl >= TMO;
    e.pc = pc; e.ra1 = int'(ins[7:4]); e.ra2 = int'(ins[3:0]); e.wa = int'(ins[11:8]);
    e.imm   = int'(op >= 5 && op <= 7);
    e.aop   = (op >= 1 && op <= 7) ? alu_of[op] : -1;
    e.nill  = int'(op >= 10 && op <= 14);
    e.berr  = int'(to);
    e.halt  = int'(op == 15 || to);
    e.nwe   = int'((op >= 1 && op <= 7) || (op == 8 && !to));
    e.wbs   = int'(op == 8);
    e.dwe   = int'(op == 9);
    e.ndreq = !mem ? 0 : to ? TMO : dl + 1;
    e.ncyc  = (op >= 1 && op <= 7) ? 3 : !mem ? 1 : to ? 2 + TMO : op == 8 ? 4 + dl : 3 + dl;
    e.npc   = e.halt ? pc : (pc + 1) % (1 << PC_W);
    return e;
  endfunction

  // Memory model: answers requests after per-instruction latencies and injects stray valids
  initial begin
    int fw = 0, dw = 0;
    stim_t s;
    bus.imem_valid = 1'b0;
    bus.dmem_valid = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      bus.imem_valid = 1'b0;
      bus.dmem_valid = 1'b0;
      bus.imem_rdata = 16'($urandom);
      if (!reset) begin
        fw = 0; dw = 0; mpc = 0;
      end else begin
        if (bus.imem_req && iq.size() > 0) begin
          if (fw >= iq[0].flat) begin
            s = iq.pop_front();
            bus.imem_rdata = s.ins;
            bus.imem_valid = 1'b1;
            cur_dlat = s.dlat;
            eq.push_back(model(s.ins, s.dlat, mpc));
            mpc = eq[$].npc;
            fw = 0;
          end else fw++;
        end else if (!bus.imem_req) bus.imem_valid = ($urandom_range(0, 7) == 0);
        if (bus.dmem_req) begin
          if (dw >= cur_dlat) begin
            bus.dmem_valid = 1'b1;
            dw = 0;
          end else dw++;
        end else bus.dmem_valid = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: an instruction is in flight from the end of its fetch until the next fetch or halt
  initial begin
    bit infl = 0, prev_req = 0, rlow = 0;
    int c = 0, o_ra1 = 0, o_ra2 = 0, o_imm = 0, o_aop = 0, o_nwe = 0, o_wa = 0, o_wbs = 0;
    int o_nill = 0, o_ndreq = 0, o_dwe = 0, o_unst = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rlow) chk("reset_outputs", int'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc, ra1, ra2, wa,
                                             we, imm, aop, wbs, halted, berr, ill}), 0);
        rlow = 1; infl = 0; prev_req = 0;
        eq.delete();
      end else begin
        rlow = 0;
        if (infl && (bus.imem_req || halted)) begin
          infl = 0;
          if (eq.size() == 0) chk("unexpected_instr", 1, 0);
          else begin
            e = eq.pop_front();
            chk("next_pc", int'(bus.pc), e.npc);
            chk("read_add1", o_ra1, e.ra1);
            chk("read_add2", o_ra2, e.ra2);
            chk("immediateC", o_imm, e.imm);
            chk("fields_stable", o_unst, 0);
            if (e.aop >= 0) chk("alu_op", o_aop, e.aop);
            chk("write_en_cycles", o_nwe, e.nwe);
            if (e.nwe > 0) begin
              chk("write_add", o_wa, e.wa);
              chk("wb_sel", o_wbs, e.wbs);
            end
            chk("illegal_pulses", o_nill, e.nill);
            chk("cycles", c, e.ncyc);
            chk("dmem_req_cycles", o_ndreq, e.ndreq);
            chk("dmem_we", o_dwe, e.dwe);
            chk("halted", int'(halted), e.halt);
            chk("bus_err", int'(berr), e.berr);
          end
        end
        if (!infl && prev_req && !bus.imem_req && !halted) begin
          infl = 1; c = 0; o_nwe = 0; o_nill = 0; o_ndreq = 0; o_dwe = 0; o_unst = 0; o_aop = 0;
          o_wa = 0; o_wbs = 0;
        end
        if (infl) begin
          if (c == 0) begin
            o_ra1 = int'(ra1); o_ra2 = int'(ra2); o_imm = int'(imm);
          end else if (int'(ra1) != o_ra1 || int'(ra2) != o_ra2 || int'(imm) != o_imm) o_unst = 1;
          if (c == 1) o_aop = int'(aop);
          if (we) begin
            o_nwe++; o_wa = int'(wa); o_wbs = int'(wbs);
          end
          o_nill += int'(ill);
          o_ndreq += int'(bus.dmem_req);
          if (bus.dmem_we) o_dwe = 1;
          c++;
        end else chk("idle_no_ctl", int'({we, ill, bus.dmem_req}), 0);
        prev_req = bus.imem_req;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_fetch", int'({bus.imem_req, bus.pc}), 1 << PC_W);
  endtask

  task automatic wait_halt(string nm);
    int k = 0;
    while (!halted && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(halted), 1);
    @(negedge clk);
    chk("queue_drained", eq.size() + iq.size(), 0);
  endtask

  initial begin
    int n;
    logic [3:0] o;
    repeat (3) @(posedge clk);
    iq.push_back('{16'h1123, 0, 0});
    iq.push_back('{16'h5A4F, 2, 0});
    iq.push_back('{16'h8350, 1, 3});
    iq.push_back('{16'h9070, 0, 0});
    iq.push_back('{16'hB000, 0, 0});
    for (int i = 5; i < 300; i++) begin
      o = (i == 255) ? 4'h0 : 4'($urandom_range(0, 14));
      iq.push_back('{{o, 12'($urandom)}, $urandom_range(0, 4), $urandom_range(0, 5)});
    end
    iq.push_back('{16'hF000, 1, 0});
    #1 reset = 1'b1;
    wait_halt("reach_halt");
    repeat (10) @(negedge clk);
    chk("halt_hold", int'({halted, bus.imem_req, bus.dmem_req, we}), 8);
    chk("halt_pc", int'(bus.pc), mpc);

    do_reset();
    n = 0;
    while (bus.imem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("fetch_timeout_cycles", n, TMO);
    chk("fetch_timeout_berr", int'({berr, halted}), 3);
    @(negedge clk);
    chk("berr_one_cycle", int'({berr, halted, bus.imem_req}), 2);

    do_reset();
    iq.push_back('{16'h8350, 0, 99});
    wait_halt("mem_timeout_halt");

    do_reset();
    iq.push_back('{16'h8120, 0, 99});
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ld_reached_mem", int'(bus.dmem_req), 1);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
